// File: rtl/timer_pkg.sv
// Register map offsets, control-bit layout and the per-channel control struct
// shared by the timer bank and its channels.
package timer_pkg;

  localparam logic [1:0] REG_LOAD   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_COUNT  = 2'd3;

  localparam int CTRL_EN_BIT       = 0;
  localparam int CTRL_PERIODIC_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT   = 2;

  typedef struct packed {
    logic irq_en;
    logic periodic;
    logic en;
  } ctrl_t;

  function automatic ctrl_t ctrl_unpack(input logic [2:0] w);
    ctrl_t c;
    c.en       = w[CTRL_EN_BIT];
    c.periodic = w[CTRL_PERIODIC_BIT];
    c.irq_en   = w[CTRL_IRQ_EN_BIT];
    return c;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: reload register, control bits, counter and
// sticky expiry flag, advanced by the shared prescaler tick.
module timer_channel
  import timer_pkg::*;
#(
  parameter int CNT_W  = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              tick_i,
  input  logic              wr_load_i,
  input  logic              wr_ctrl_i,
  input  logic              wr_status_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic [CNT_W-1:0]  count_o,
  output logic [CNT_W-1:0]  load_o,
  output ctrl_t             ctrl_o,
  output logic              expired_o
);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] load_q, load_d;
  ctrl_t            ctrl_q, ctrl_d;
  logic             expired_q, expired_d;

  // Only the low bits of the bus matter to a channel.
  logic unused_wr_data;
  assign unused_wr_data = ^wr_data_i;

  always_comb begin
    load_d    = load_q;
    ctrl_d    = ctrl_q;
    count_d   = count_q;
    expired_d = expired_q;

    if (wr_load_i)                   load_d    = wr_data_i[CNT_W-1:0];
    if (wr_status_i && wr_data_i[0]) expired_d = 1'b0;
    if (wr_ctrl_i)                   ctrl_d    = ctrl_unpack(wr_data_i[2:0]);

    // A fresh enable reloads from the previously registered LOAD and
    // suppresses this cycle's tick; expiry is applied after W1C so set wins.
    if (wr_ctrl_i && ctrl_d.en && !ctrl_q.en) begin
      count_d = load_q;
    end else if (ctrl_q.en && ctrl_d.en && tick_i) begin
      if (count_q != '0) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        expired_d = 1'b1;
        if (ctrl_d.periodic) count_d = load_q;
        else                 ctrl_d.en = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q   <= '0;
      load_q    <= '0;
      ctrl_q    <= '0;
      expired_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      load_q    <= load_d;
      ctrl_q    <= ctrl_d;
      expired_q <= expired_d;
    end
  end

  assign count_o   = count_q;
  assign load_o    = load_q;
  assign ctrl_o    = ctrl_q;
  assign expired_o = expired_q;

endmodule

// File: rtl/timer_bank.sv
// Bank of NUM_CH timer channels behind a register read/write port, with a
// shared prescaler and a registered combined interrupt.
module timer_bank
  import timer_pkg::*;
#(
  parameter int  NUM_CH = 4,
  parameter int  CNT_W  = 32,
  parameter int  PRESC  = 0,
  parameter int  DATA_W = 32,
  localparam int AW     = $clog2(NUM_CH) + 2,
  localparam int PW     = (PRESC > 0) ? $clog2(PRESC + 1) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_req,
  input  logic [AW-1:0]     rd_addr,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic [NUM_CH-1:0] timer_is_high,
  output logic              irq
);

  logic [PW-1:0]     presc_q, presc_d;
  logic              tick;
  logic [AW-1:0]     wr_ch, rd_ch;
  logic [CNT_W-1:0]  count [NUM_CH];
  logic [CNT_W-1:0]  load  [NUM_CH];
  ctrl_t             ctrl  [NUM_CH];
  logic [NUM_CH-1:0] expired, irq_src;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              rd_valid_q, irq_q;

  assign tick    = (presc_q == PW'(PRESC));
  assign presc_d = tick ? '0 : presc_q + PW'(1);

  // Channel field sits above the 2-bit register offset; out-of-range
  // channels simply match no instance.
  assign wr_ch = wr_addr >> 2;
  assign rd_ch = rd_addr >> 2;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic sel;
    assign sel = wr_en && (wr_ch == AW'(c));

    timer_channel #(
      .CNT_W (CNT_W),
      .DATA_W(DATA_W)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .tick_i     (tick),
      .wr_load_i  (sel && (wr_addr[1:0] == REG_LOAD)),
      .wr_ctrl_i  (sel && (wr_addr[1:0] == REG_CTRL)),
      .wr_status_i(sel && (wr_addr[1:0] == REG_STATUS)),
      .wr_data_i  (wr_data),
      .count_o    (count[c]),
      .load_o     (load[c]),
      .ctrl_o     (ctrl[c]),
      .expired_o  (expired[c])
    );

    assign irq_src[c] = expired[c] & ctrl[c].irq_en;
  end

  always_comb begin
    rd_word = '0;
    for (int ch = 0; ch < NUM_CH; ch++) begin
      if (rd_ch == AW'(ch)) begin
        case (rd_addr[1:0])
          REG_LOAD:   rd_word = DATA_W'(load[ch]);
          REG_CTRL:   rd_word = DATA_W'(ctrl[ch]);
          REG_STATUS: rd_word = DATA_W'(expired[ch]);
          default:    rd_word = DATA_W'(count[ch]);
        endcase
      end
    end
  end

  assign rd_data_d = rd_req ? rd_word : rd_data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      irq_q      <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      rd_valid_q <= rd_req;
      rd_data_q  <= rd_data_d;
      irq_q      <= |irq_src;
    end
  end

  assign rd_valid      = rd_valid_q;
  assign rd_data       = rd_data_q;
  assign timer_is_high = expired;
  assign irq           = irq_q;

endmodule

// File: tb/tb_timer_bank.sv
// Directed bench for timer_bank: a 3-channel PRESC=0 instance (dut0) and a
// 4-channel PRESC=3 instance (dut3) share one stimulus port.
module tb_timer_bank;

  logic        clk = 1'b0, rst = 1'b1, wr_en = 1'b0, rd_req = 1'b0;
  logic [3:0]  wr_addr = '0, rd_addr = '0;
  logic [31:0] wr_data = '0;
  logic        rv0, rv3, irq0, irq3;
  logic [31:0] rd0, rd3;
  logic [2:0]  th0;
  logic [3:0]  th3;
  int          checks = 0, fails = 0, cyc = 0;

  timer_bank #(.NUM_CH(3), .CNT_W(32), .PRESC(0), .DATA_W(32)) dut0 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rv0), .rd_data(rd0),
    .timer_is_high(th0), .irq(irq0));

  timer_bank #(.NUM_CH(4), .CNT_W(32), .PRESC(3), .DATA_W(32)) dut3 (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rv3), .rd_data(rd3),
    .timer_is_high(th3), .irq(irq3));

  always #5 clk = ~clk;

  // Edges since reset release: after edge Ek, cyc == k.
  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; wr_en = 1'b0; rd_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a);
    rd_req = 1'b1; rd_addr = a;
    @(negedge clk);
    rd_req = 1'b0;
  endtask

  task automatic to_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (cyc != n) begin
      fails++;
      $display("FAIL sync: cyc %0d expected %0d", cyc, n);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({irq0, irq3} !== 2'b00) begin fails++; $display("FAIL reset_irq: got %b expected 00", {irq0, irq3}); end
    checks++; if ({th0, th3} !== 7'b0) begin fails++; $display("FAIL reset_th: got %b expected 0", {th0, th3}); end
    checks++; if ({rv0, rv3} !== 2'b00) begin fails++; $display("FAIL reset_rv: got %b expected 00", {rv0, rv3}); end
    for (int a = 0; a < 16; a++) begin
      rd(4'(a));
      checks++; if ({rv0, rv3} !== 2'b11) begin fails++; $display("FAIL reset_rd_valid[%0d]: got %b expected 11", a, {rv0, rv3}); end
      checks++; if (rd0 !== 32'd0 || rd3 !== 32'd0) begin fails++; $display("FAIL reset_rd_data[%0d]: got %h/%h expected 0", a, rd0, rd3); end
      @(negedge clk);
      checks++; if ({rv0, rv3} !== 2'b00) begin fails++; $display("FAIL reset_rd_valid_drop[%0d]: got %b expected 00", a, {rv0, rv3}); end
    end
  endtask

  task automatic test_oneshot();
    do_reset();
    wr(4'h0, 32'd5);
    wr(4'h1, 32'h1);
    for (int k = 2; k <= 8; k++) begin
      to_cyc(k);
      checks++; if (th0[0] !== (k >= 8)) begin fails++; $display("FAIL oneshot_th cyc%0d: got %b expected %b", k, th0[0], (k >= 8)); end
    end
    rd(4'h3);
    checks++; if (rv0 !== 1'b1 || rd0 !== 32'd0) begin fails++; $display("FAIL oneshot_count: got v%b %h expected v1 0", rv0, rd0); end
    rd(4'h1);
    checks++; if (rd0 !== 32'd0) begin fails++; $display("FAIL oneshot_ctrl: got %h expected 0", rd0); end
    rd(4'h2);
    checks++; if (rd0 !== 32'd1) begin fails++; $display("FAIL oneshot_status: got %h expected 1", rd0); end
  endtask

  task automatic test_periodic_irq();
    do_reset();
    wr(4'h4, 32'd3);
    wr(4'h5, 32'h7);
    to_cyc(5);
    checks++; if ({th0[1], irq0} !== 2'b00) begin fails++; $display("FAIL per_c5: got %b expected 00", {th0[1], irq0}); end
    to_cyc(6);
    checks++; if ({th0[1], irq0} !== 2'b10) begin fails++; $display("FAIL per_c6: got %b expected 10", {th0[1], irq0}); end
    to_cyc(7);
    checks++; if (irq0 !== 1'b1) begin fails++; $display("FAIL per_irq_c7: got %b expected 1", irq0); end
    wr(4'h6, 32'h1);
    checks++; if ({th0[1], irq0} !== 2'b01) begin fails++; $display("FAIL per_w1c_c8: got %b expected 01", {th0[1], irq0}); end
    to_cyc(9);
    checks++; if (irq0 !== 1'b0) begin fails++; $display("FAIL per_irq_c9: got %b expected 0", irq0); end
    to_cyc(10);
    checks++; if (th0[1] !== 1'b1) begin fails++; $display("FAIL per_reexp_c10: got %b expected 1", th0[1]); end
    to_cyc(11);
    checks++; if (irq0 !== 1'b1) begin fails++; $display("FAIL per_irq_c11: got %b expected 1", irq0); end
    rd(4'h7);
    checks++; if (rd0 !== 32'd2) begin fails++; $display("FAIL per_count_sample: got %h expected 2", rd0); end
    wr(4'h5, 32'h3);
    checks++; if (irq0 !== 1'b1) begin fails++; $display("FAIL per_irq_c13: got %b expected 1", irq0); end
    to_cyc(14);
    checks++; if ({th0[1], irq0} !== 2'b10) begin fails++; $display("FAIL per_irqen_off: got %b expected 10", {th0[1], irq0}); end
  endtask

  task automatic test_set_wins();
    do_reset();
    wr(4'h8, 32'd2);
    wr(4'h9, 32'h3);
    to_cyc(4);
    checks++; if (th0[2] !== 1'b0) begin fails++; $display("FAIL setwins_c4: got %b expected 0", th0[2]); end
    wr(4'hA, 32'h1);
    checks++; if (th0[2] !== 1'b1) begin fails++; $display("FAIL setwins_c5: got %b expected 1", th0[2]); end
    wr(4'hA, 32'h1);
    checks++; if (th0[2] !== 1'b0) begin fails++; $display("FAIL setwins_w1c_c6: got %b expected 0", th0[2]); end
    rd(4'hA);
    rd(4'hA);
    checks++; if (rd0 !== 32'd0) begin fails++; $display("FAIL setwins_status_pre: got %h expected 0", rd0); end
    rd(4'hA);
    checks++; if (rd0 !== 32'd1) begin fails++; $display("FAIL setwins_status_post: got %h expected 1", rd0); end
  endtask

  task automatic test_prescaler();
    do_reset();
    wr(4'hC, 32'd1);
    to_cyc(3);
    wr(4'hD, 32'h1);
    to_cyc(5);
    wr(4'hC, 32'd10);
    to_cyc(11);
    checks++; if (th3[3] !== 1'b0) begin fails++; $display("FAIL presc_c11: got %b expected 0", th3[3]); end
    to_cyc(12);
    checks++; if (th3[3] !== 1'b1) begin fails++; $display("FAIL presc_c12: got %b expected 1", th3[3]); end
    checks++; if (th0 !== 3'b000) begin fails++; $display("FAIL oor_th0: got %b expected 000", th0); end
    rd(4'hF);
    checks++; if (rd3 !== 32'd0) begin fails++; $display("FAIL presc_count_end: got %h expected 0", rd3); end
    checks++; if (rv0 !== 1'b1 || rd0 !== 32'd0) begin fails++; $display("FAIL oor_read: got v%b %h expected v1 0", rv0, rd0); end
    rd(4'hD);
    checks++; if (rd3 !== 32'd0) begin fails++; $display("FAIL presc_ctrl_end: got %h expected 0", rd3); end
    wr(4'hE, 32'h1);
    wr(4'hD, 32'h1);
    checks++; if (th3[3] !== 1'b0) begin fails++; $display("FAIL presc_w1c: got %b expected 0", th3[3]); end
    rd(4'hF);
    checks++; if (rd3 !== 32'd10) begin fails++; $display("FAIL presc_reload: got %h expected a", rd3); end
    rd(4'hC);
    checks++; if (rd3 !== 32'd10) begin fails++; $display("FAIL presc_load: got %h expected a", rd3); end
    to_cyc(59);
    checks++; if (th3[3] !== 1'b0) begin fails++; $display("FAIL presc_c59: got %b expected 0", th3[3]); end
    to_cyc(60);
    checks++; if (th3[3] !== 1'b1) begin fails++; $display("FAIL presc_c60: got %b expected 1", th3[3]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    wr(4'h0, 32'd1);
    wr(4'h4, 32'd9);
    wr(4'h1, 32'h7);
    wr(4'h5, 32'h7);
    to_cyc(6);
    rd(4'h5);
    checks++; if ({rv0, irq0, th0[0]} !== 3'b111 || rd0 !== 32'd7) begin fails++; $display("FAIL mid_pre: got %b %h expected 111 7", {rv0, irq0, th0[0]}, rd0); end
    rd_req = 1'b1; rd_addr = 4'h7;
    #2 rst = 1'b0;
    #1;
    checks++; if ({rv0, irq0, th0, rv3, irq3, th3} !== 11'b0) begin fails++; $display("FAIL mid_async: got %b expected 0", {rv0, irq0, th0, rv3, irq3, th3}); end
    checks++; if (rd0 !== 32'd0 || rd3 !== 32'd0) begin fails++; $display("FAIL mid_rd_data: got %h/%h expected 0", rd0, rd3); end
    @(posedge clk); #1;
    checks++; if ({rv0, rv3} !== 2'b00) begin fails++; $display("FAIL mid_no_valid: got %b expected 00", {rv0, rv3}); end
    @(negedge clk);
    rd_req = 1'b0; rst = 1'b1;
    to_cyc(3);
    rd(4'h7);
    checks++; if (rd0 !== 32'd0) begin fails++; $display("FAIL mid_ch1_count: got %h expected 0", rd0); end
    rd(4'h5);
    checks++; if (rd0 !== 32'd0) begin fails++; $display("FAIL mid_ch1_ctrl: got %h expected 0", rd0); end
    rd(4'h3);
    checks++; if (rd0 !== 32'd0) begin fails++; $display("FAIL mid_ch0_count: got %h expected 0", rd0); end
    checks++; if ({th0, irq0} !== 4'b0) begin fails++; $display("FAIL mid_idle: got %b expected 0", {th0, irq0}); end
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_periodic_irq();
    test_set_wins();
    test_prescaler();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
Name: timer_bank

Overview:
- Parametrised successor to the single-channel digital timer.
- Provides NUM_CH independent down-counting timers behind one register-style read/write port driven by the mmu.
- Each channel has a one-shot or periodic mode, a sticky expiry flag (timer_is_high per channel) and an interrupt enable.
- A shared prescaler generates the count tick; a combined interrupt line is exported for the core.

Parameters:
- NUM_CH, 4, number of timer channels (1..16).
- CNT_W, 32, counter/reload width in bits (1..32).
- PRESC, 0, prescaler divide-minus-one; tick asserted every PRESC+1 clocks.
- DATA_W, 32, register bus width.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-low.
- wr_en  in  1  register write strobe, single cycle.
- wr_addr  in  $clog2(NUM_CH)+2  {channel, reg[1:0]}.
- wr_data  in  DATA_W  write data.
- rd_req  in  1  register read request.
- rd_addr  in  $clog2(NUM_CH)+2  {channel, reg[1:0]}.
- rd_valid  out  1  read data valid, one cycle after rd_req.
- rd_data  out  DATA_W  read data.
- timer_is_high  out  NUM_CH  per-channel sticky expiry flag.
- irq  out  1  OR over channels of (expired & irq_en), registered.

Behaviour:
- Register map per channel (reg[1:0]):
  - 0 LOAD: reload value, low CNT_W bits kept.
  - 1 CTRL: bit0 en, bit1 periodic, bit2 irq_en.
  - 2 STATUS: bit0 expired; write 1 to clear.
  - 3 COUNT: read-only; writes ignored.
- Reads zero-extend to DATA_W. Unused CTRL/STATUS bits read 0.
- Reset: all LOAD, COUNT, CTRL and expired bits = 0; prescaler counter = 0; rd_valid = 0; rd_data = 0; irq = 0; timer_is_high = 0.
- Prescaler: free-running counter 0..PRESC. tick = (presc_cnt == PRESC). With PRESC=0, tick is asserted every cycle.
- Writes take effect on the clock edge where wr_en is high. New state is visible from the next cycle.
- CTRL write, en 0->1: COUNT <= LOAD (the current registered value, not a same-cycle LOAD write).
- CTRL write, en 1->0: COUNT freezes at its current value. A later re-enable reloads from LOAD.
- Channel counting, when en and tick:
  - COUNT != 0: COUNT <= COUNT-1.
  - COUNT == 0: expired <= 1. If periodic, COUNT <= LOAD; otherwise en <= 0 and COUNT stays 0.
  - Result: period = LOAD+1 ticks, so LOAD=0 expires on every tick.
- A LOAD write while running changes only the next reload; the current COUNT is not touched.
- Expiry and STATUS W1C in the same cycle: set wins, expired stays 1.
- CTRL write en 0->1 and tick in the same cycle: the load wins; no decrement that cycle.
- irq is registered and follows expired & irq_en with 1-cycle latency. Clearing irq_en deasserts irq on the next cycle without clearing expired.
- Read handshake: rd_req in cycle N gives rd_valid = 1 with rd_data in cycle N+1.
  - Back-to-back reads are accepted every cycle.
  - COUNT is sampled at cycle N, before that cycle's update.
- Channel index >= NUM_CH: writes ignored, reads return 0 with rd_valid still asserted.
- Reset asserted mid-operation clears everything immediately, asynchronously; no pending read completes.

Decomposition:
- timer_pkg holds the register offset constants (REG_LOAD/CTRL/STATUS/COUNT), CTRL bit positions and the ctrl_t packed struct {irq_en, periodic, en}.
- One sub-module, timer_channel, instantiated NUM_CH times. It contains the counter, reload register, ctrl_t and expired flag, with inputs tick, wr strobes per register and wr_data.
- timer_bank holds the prescaler, address decode, read mux/register and the irq OR.

Test Plan:
- Reset, then read every register of every channel -> all reads 0, rd_valid exactly 1 cycle after each rd_req, irq=0, timer_is_high=0.
- Ch0, PRESC=0: LOAD=5, CTRL=0x1 (one-shot) -> timer_is_high[0] rises 6 cycles after the enable takes effect. COUNT then reads 0 and CTRL.en reads 0.
- Ch1: LOAD=3, CTRL=0x7 -> expired every 4 ticks. irq asserts 1 cycle after the first expiry. W1C to STATUS drops irq 2 cycles later (flag clear, then irq register), and the flag re-sets at the next expiry.
- Ch2 periodic, LOAD=2: write STATUS=1 in the exact cycle of expiry -> expired remains 1 (set wins).
- PRESC=3 build, ch3 LOAD=1 one-shot -> expiry after 8 clocks. Mid-count, LOAD=10 write -> current run unaffected; a re-enable then counts 11 ticks.
- Assert rst while two channels run and a read is pending -> all outputs 0 immediately, no rd_valid; after release, counters hold 0 and stay disabled.
